// File: rtl/axi_mcast_b_joiner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_mcast_b_joiner                                              |
// | Brief    : Collects one B beat per selected master port for each committed |
// |            multicast write and returns a single merged B to the slave port.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module axi_mcast_b_joiner #(
    parameter int unsigned NoMstPorts = 4,
    parameter int unsigned MaxTrans   = 8,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned UserWidth  = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            aw_valid_i,
    output logic                            aw_ready_o,
    input  logic [NoMstPorts-1:0]           aw_mask_i,
    input  logic [IdWidth-1:0]              aw_id_i,
    input  logic [NoMstPorts-1:0]           mst_b_valid_i,
    output logic [NoMstPorts-1:0]           mst_b_ready_o,
    input  logic [NoMstPorts*IdWidth-1:0]   mst_b_id_i,
    input  logic [NoMstPorts*2-1:0]         mst_b_resp_i,
    input  logic [NoMstPorts*UserWidth-1:0] mst_b_user_i,
    output logic                            slv_b_valid_o,
    input  logic                            slv_b_ready_i,
    output logic [IdWidth-1:0]              slv_b_id_o,
    output logic [1:0]                      slv_b_resp_o,
    output logic [UserWidth-1:0]            slv_b_user_o
);

    localparam int unsigned C_PTR_W = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned C_CNT_W = $clog2(MaxTrans + 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_RESPOND = 1'b1
    } state_e;

    state_e                  state_q;
    logic [NoMstPorts-1:0]   mask_mem_q [MaxTrans];
    logic [IdWidth-1:0]      id_mem_q   [MaxTrans];
    logic [C_PTR_W-1:0]      wr_ptr_q;
    logic [C_PTR_W-1:0]      rd_ptr_q;
    logic [C_CNT_W-1:0]      count_q;
    logic [NoMstPorts-1:0]   rcvd_q;
    logic                    dec_q;
    logic                    slv_q;
    logic                    okay_q;
    logic [UserWidth-1:0]    user_acc_q;
    logic [IdWidth-1:0]      slv_id_q;
    logic [1:0]              slv_resp_q;
    logic [UserWidth-1:0]    slv_user_q;

    logic                    dec_d;
    logic                    slv_d;
    logic                    okay_d;
    logic [UserWidth-1:0]    user_acc_d;
    logic                    w_head_valid;
    logic [NoMstPorts-1:0]   w_head_mask;
    logic [IdWidth-1:0]      w_head_id;
    logic                    w_push;
    logic                    w_pop;
    logic [NoMstPorts-1:0]   w_hs;
    logic                    w_done;
    logic [1:0]              w_merged_resp;

    function automatic logic [C_PTR_W-1:0] f_ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(MaxTrans - 1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    assign w_head_valid  = (count_q != '0);
    assign w_head_mask   = mask_mem_q[rd_ptr_q];
    assign w_head_id     = id_mem_q[rd_ptr_q];
    assign aw_ready_o    = (count_q != C_CNT_W'(MaxTrans));
    assign w_push        = aw_valid_i & aw_ready_o;
    assign w_pop         = (state_q == ST_RESPOND) & slv_b_ready_i;
    assign mst_b_ready_o = (w_head_valid && state_q == ST_COLLECT) ? (w_head_mask & ~rcvd_q) : '0;
    assign w_hs          = mst_b_valid_i & mst_b_ready_o;

    assign slv_b_valid_o = (state_q == ST_RESPOND);
    assign slv_b_id_o    = slv_id_q;
    assign slv_b_resp_o  = slv_resp_q;
    assign slv_b_user_o  = slv_user_q;

    // okay_d remembers that some port returned plain OKAY, which spoils an all-EXOKAY merge
    always_comb begin
        dec_d      = dec_q;
        slv_d      = slv_q;
        okay_d     = okay_q;
        user_acc_d = user_acc_q;
        for (int i = 0; i < int'(NoMstPorts); i++) begin
            if (w_hs[i]) begin
                case (mst_b_resp_i[2*i +: 2])
                    2'd3:    dec_d  = 1'b1;
                    2'd2:    slv_d  = 1'b1;
                    2'd1:    ;
                    default: okay_d = 1'b1;
                endcase
                user_acc_d = user_acc_d | mst_b_user_i[i*UserWidth +: UserWidth];
            end
        end
        w_done = w_head_valid && ((rcvd_q | w_hs) == w_head_mask);
        if (dec_d || (w_head_mask == '0)) begin
            w_merged_resp = 2'd3;
        end else if (slv_d) begin
            w_merged_resp = 2'd2;
        end else if (!okay_d) begin
            w_merged_resp = 2'd1;
        end else begin
            w_merged_resp = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mask_mem_q[wr_ptr_q] <= aw_mask_i;
            id_mem_q[wr_ptr_q]   <= aw_id_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_COLLECT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rcvd_q     <= '0;
            dec_q      <= 1'b0;
            slv_q      <= 1'b0;
            okay_q     <= 1'b0;
            user_acc_q <= '0;
            slv_id_q   <= '0;
            slv_resp_q <= '0;
            slv_user_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= f_ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= f_ptr_inc(rd_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + C_CNT_W'(1);
                2'b01:   count_q <= count_q - C_CNT_W'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                ST_COLLECT: begin
                    rcvd_q     <= rcvd_q | w_hs;
                    dec_q      <= dec_d;
                    slv_q      <= slv_d;
                    okay_q     <= okay_d;
                    user_acc_q <= user_acc_d;
                    if (w_done) begin
                        state_q    <= ST_RESPOND;
                        slv_id_q   <= w_head_id;
                        slv_resp_q <= w_merged_resp;
                        slv_user_q <= user_acc_d;
                    end
                end
                ST_RESPOND: begin
                    if (slv_b_ready_i) begin
                        state_q    <= ST_COLLECT;
                        rcvd_q     <= '0;
                        dec_q      <= 1'b0;
                        slv_q      <= 1'b0;
                        okay_q     <= 1'b0;
                        user_acc_q <= '0;
                        slv_id_q   <= '0;
                        slv_resp_q <= '0;
                        slv_user_q <= '0;
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A B beat accepted for the head entry must carry the head's ID
    for (genvar g = 0; g < int'(NoMstPorts); g++) begin : g_id_chk
        a_b_id_match: assert property (@(posedge clk_i) disable iff (rst_i)
            w_hs[g] |-> (mst_b_id_i[g*IdWidth +: IdWidth] == w_head_id));
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_mcast_b_joiner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi_mcast_b_joiner                                           |
// | Brief    : Directed and random stimulus against a queue-based model.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_axi_mcast_b_joiner;

    localparam int NP   = 4;
    localparam int MAXT = 8;
    localparam int IW   = 4;
    localparam int UW   = 1;

    typedef struct packed {
        logic [NP-1:0]   mask;
        logic [IW-1:0]   id;
        logic [2*NP-1:0] resp;
        logic [NP-1:0]   user;
    } ent_t;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                aw_valid_i = 1'b0;
    logic                aw_ready_o;
    logic [NP-1:0]       aw_mask_i = '0;
    logic [IW-1:0]       aw_id_i = '0;
    logic [NP-1:0]       mst_b_valid_i = '0;
    logic [NP-1:0]       mst_b_ready_o;
    logic [NP*IW-1:0]    mst_b_id_i = '0;
    logic [NP*2-1:0]     mst_b_resp_i = '0;
    logic [NP*UW-1:0]    mst_b_user_i = '0;
    logic                slv_b_valid_o;
    logic                slv_b_ready_i = 1'b0;
    logic [IW-1:0]       slv_b_id_o;
    logic [1:0]          slv_b_resp_o;
    logic [UW-1:0]       slv_b_user_o;

    ent_t            q[$];
    logic [NP-1:0]   got;
    bit              respond;
    logic [2*NP-1:0] nxt_resp;
    logic [NP-1:0]   nxt_user;
    int              n_checks = 0;
    int              n_errors = 0;
    int              n_pushed = 0;
    int              n_merged = 0;

    axi_mcast_b_joiner #(
        .NoMstPorts (NP),
        .MaxTrans   (MAXT),
        .IdWidth    (IW),
        .UserWidth  (UW)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .aw_valid_i    (aw_valid_i),
        .aw_ready_o    (aw_ready_o),
        .aw_mask_i     (aw_mask_i),
        .aw_id_i       (aw_id_i),
        .mst_b_valid_i (mst_b_valid_i),
        .mst_b_ready_o (mst_b_ready_o),
        .mst_b_id_i    (mst_b_id_i),
        .mst_b_resp_i  (mst_b_resp_i),
        .mst_b_user_i  (mst_b_user_i),
        .slv_b_valid_o (slv_b_valid_o),
        .slv_b_ready_i (slv_b_ready_i),
        .slv_b_id_o    (slv_b_id_o),
        .slv_b_resp_o  (slv_b_resp_o),
        .slv_b_user_o  (slv_b_user_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Merged response from the rules: any DECERR, else any SLVERR, else all EXOKAY, else OKAY
    function automatic logic [1:0] merge_resp(input ent_t e);
        int nsel = 0, ndec = 0, nslv = 0, nexo = 0;
        for (int p = 0; p < NP; p++) begin
            if (e.mask[p]) begin
                nsel++;
                if (e.resp[2*p +: 2] == 2'd3) ndec++;
                if (e.resp[2*p +: 2] == 2'd2) nslv++;
                if (e.resp[2*p +: 2] == 2'd1) nexo++;
            end
        end
        if (nsel == 0 || ndec > 0) return 2'd3;
        if (nslv > 0) return 2'd2;
        if (nexo == nsel) return 2'd1;
        return 2'd0;
    endfunction

    // Oldest pending entry for which port p still owes a B beat
    function automatic int front_idx(input int p);
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].mask[p] && !(k == 0 && got[p])) return k;
        end
        return -1;
    endfunction

    task automatic step(input bit av, input logic [NP-1:0] am, input logic [IW-1:0] aid,
                        input logic [NP-1:0] ben, input bit srdy);
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] hs;
        bit            push;
        bit            pop;
        ent_t          e;
        aw_valid_i    = av;
        aw_mask_i     = am;
        aw_id_i       = aid;
        slv_b_ready_i = srdy;
        mst_b_valid_i = '0;
        mst_b_id_i    = '0;
        mst_b_resp_i  = '0;
        mst_b_user_i  = '0;
        for (int p = 0; p < NP; p++) begin
            automatic int k = front_idx(p);
            if (k >= 0 && ben[p]) begin
                mst_b_valid_i[p]         = 1'b1;
                mst_b_id_i[p*IW +: IW]   = q[k].id;
                mst_b_resp_i[2*p +: 2]   = q[k].resp[2*p +: 2];
                mst_b_user_i[p]          = q[k].user[p];
            end
        end
        #1;
        exp_rdy = '0;
        if (q.size() > 0 && !respond) exp_rdy = q[0].mask & ~got;
        check("aw_ready", aw_ready_o, q.size() < MAXT);
        check("mst_b_ready", mst_b_ready_o, exp_rdy);
        check("slv_b_valid", slv_b_valid_o, respond);
        if (respond) begin
            check("slv_b_id", slv_b_id_o, q[0].id);
            check("slv_b_resp", slv_b_resp_o, merge_resp(q[0]));
            check("slv_b_user", slv_b_user_o, |(q[0].user & q[0].mask));
        end
        hs   = mst_b_valid_i & exp_rdy;
        push = av && (q.size() < MAXT);
        pop  = respond && srdy;
        @(posedge clk_i);
        if (pop) begin
            void'(q.pop_front());
            got     = '0;
            respond = 1'b0;
            n_merged++;
        end else if (q.size() > 0 && !respond) begin
            got = got | hs;
            if (got == q[0].mask) respond = 1'b1;
        end
        if (push) begin
            e.mask = am;
            e.id   = aid;
            e.resp = nxt_resp;
            e.user = nxt_user;
            q.push_back(e);
            n_pushed++;
        end
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_aw_ready"}, aw_ready_o, 1);
        check({tag, "_mst_b_ready"}, mst_b_ready_o, 0);
        check({tag, "_slv_b_valid"}, slv_b_valid_o, 0);
        check({tag, "_slv_b_id"}, slv_b_id_o, 0);
        check({tag, "_slv_b_resp"}, slv_b_resp_o, 0);
        check({tag, "_slv_b_user"}, slv_b_user_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed running expected done");
        $fatal(1);
    end

    initial begin
        int target;
        got = '0;
        respond = 1'b0;
        nxt_resp = '0;
        nxt_user = '0;

        // Reset at start, then asynchronous reset in the middle of traffic
        #2;
        check_reset_outs("rst0");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        step(1'b1, 4'b0000, 4'd9, 4'h0, 1'b0);
        step(1'b0, 4'b0000, 4'd0, 4'h0, 1'b0);
        step(1'b1, 4'b1111, 4'd2, 4'h0, 1'b0);
        step(1'b0, 4'b0000, 4'd0, 4'h1, 1'b0);
        #3;
        rst_i = 1'b1;
        #1;
        check_reset_outs("rst_mid");
        q.delete();
        got = '0;
        respond = 1'b0;
        n_pushed = 0;
        n_merged = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_rel_aw_ready", aw_ready_o, 1);
        repeat (3) step(1'b0, 4'b0000, 4'd0, 4'hF, 1'b1);

        // Multicast OKAY join, ports 0, 3, 1 on separate cycles
        step(1'b1, 4'b1011, 4'd5, 4'h0, 1'b0);
        step(1'b0, 4'b0000, 4'd0, 4'b0001, 1'b0);
        check("mc_p0_valid", slv_b_valid_o, 0);
        check("mc_p0_rdy2", mst_b_ready_o[2], 0);
        step(1'b0, 4'b0000, 4'd0, 4'b1000, 1'b0);
        check("mc_p3_valid", slv_b_valid_o, 0);
        check("mc_p3_rdy2", mst_b_ready_o[2], 0);
        step(1'b0, 4'b0000, 4'd0, 4'b0010, 1'b0);
        check("mc_p1_valid", slv_b_valid_o, 1);
        check("mc_id", slv_b_id_o, 5);
        check("mc_resp", slv_b_resp_o, 0);
        step(1'b0, 4'b0000, 4'd0, 4'h0, 1'b1);
        check("mc_popped", slv_b_valid_o, 0);

        // Simultaneous arrival with error merge, then all EXOKAY
        nxt_resp = {2'd3, 2'd1, 2'd2, 2'd0};
        nxt_user = 4'b0010;
        step(1'b1, 4'b1111, 4'd3, 4'h0, 1'b0);
        step(1'b0, 4'b0000, 4'd0, 4'hF, 1'b0);
        check("err_valid", slv_b_valid_o, 1);
        check("err_resp", slv_b_resp_o, 3);
        check("err_user", slv_b_user_o, 1);
        step(1'b0, 4'b0000, 4'd0, 4'h0, 1'b1);
        nxt_resp = 8'b01_01_01_01;
        nxt_user = 4'b0000;
        step(1'b1, 4'b1111, 4'd4, 4'h0, 1'b0);
        step(1'b0, 4'b0000, 4'd0, 4'hF, 1'b0);
        check("exo_valid", slv_b_valid_o, 1);
        check("exo_resp", slv_b_resp_o, 1);
        check("exo_user", slv_b_user_o, 0);
        step(1'b0, 4'b0000, 4'd0, 4'h0, 1'b1);

        // Ordering under slave-side backpressure
        nxt_resp = '0;
        step(1'b1, 4'b0001, 4'd1, 4'h0, 1'b0);
        step(1'b1, 4'b0001, 4'd2, 4'h0, 1'b0);
        step(1'b1, 4'b0001, 4'd3, 4'h0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 4'b0000, 4'd0, 4'b0001, 1'b0);
            check("ord_valid", slv_b_valid_o, 1);
            check("ord_id", slv_b_id_o, k);
            repeat (5) begin
                step(1'b0, 4'b0000, 4'd0, 4'b0001, 1'b0);
                check("ord_bp_rdy0", mst_b_ready_o[0], 0);
                check("ord_bp_id", slv_b_id_o, k);
            end
            step(1'b0, 4'b0000, 4'd0, 4'b0001, 1'b1);
        end

        // Empty mask
        step(1'b1, 4'b0000, 4'd7, 4'h0, 1'b0);
        check("empty_t1_valid", slv_b_valid_o, 0);
        step(1'b0, 4'b0000, 4'd0, 4'hF, 1'b0);
        check("empty_valid", slv_b_valid_o, 1);
        check("empty_id", slv_b_id_o, 7);
        check("empty_resp", slv_b_resp_o, 3);
        check("empty_user", slv_b_user_o, 0);
        check("empty_mst_rdy", mst_b_ready_o, 0);
        step(1'b0, 4'b0000, 4'd0, 4'h0, 1'b1);

        // Fill to full, then random drain-while-pushing with wrap-around
        for (int i = 0; i < MAXT; i++) begin
            nxt_resp = 8'($urandom);
            nxt_user = 4'($urandom);
            step(1'b1, 4'($urandom_range(1, 15)), 4'(i), 4'h0, 1'b0);
        end
        check("full_aw_ready", aw_ready_o, 0);
        target = n_pushed + 3 * MAXT + 40;
        for (int c = 0; c < 6000 && (n_pushed < target || q.size() > 0); c++) begin
            automatic bit av = (n_pushed < target) && ($urandom_range(0, 3) != 0);
            automatic logic [NP-1:0] m = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            nxt_resp = 8'($urandom);
            nxt_user = 4'($urandom);
            step(av, m, 4'($urandom), 4'($urandom), $urandom_range(0, 2) != 0);
        end
        check("drain_left", q.size(), 0);
        check("beat_count", n_merged, n_pushed);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_mcast_b_joiner.md
# axi_mcast_b_joiner

Response-side counterpart of the multicast write fork. Each committed write's destination mask and ID are recorded in order. The block then collects one B beat from every selected master port and returns a single merged B beat to the initiating slave port. It sits between the per-master B channels and the slave-port B channel of the multicast crossbar. It also handles unicast (one-hot mask) writes.

## Interface
- NoMstPorts, default 4: number of destination master ports; must be ≥1.
- MaxTrans, default 8: depth of the pending-write FIFO; must be ≥2.
- IdWidth, default 4: B/AW ID width.
- UserWidth, default 1: B user width.

Ports (name, direction, width, meaning):
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- aw_valid_i  in  1  a write was committed at the fork.
- aw_ready_o  out  1  pending FIFO can accept an entry.
- aw_mask_i  in  NoMstPorts  destination master ports of the write.
- aw_id_i  in  IdWidth  write ID.
- mst_b_valid_i  in  NoMstPorts  per-master B valid.
- mst_b_ready_o  out  NoMstPorts  per-master B ready.
- mst_b_id_i  in  NoMstPorts*IdWidth  per-master B ID.
- mst_b_resp_i  in  NoMstPorts*2  per-master B resp.
- mst_b_user_i  in  NoMstPorts*UserWidth  per-master B user.
- slv_b_valid_o  out  1  merged B valid.
- slv_b_ready_i  in  1  merged B ready.
- slv_b_id_o  out  IdWidth  merged B ID (the head entry's ID).
- slv_b_resp_o  out  2  merged B resp.
- slv_b_user_o  out  UserWidth  merged B user.

## Operation
- Pending FIFO stores {mask, id}, depth MaxTrans, in commit order.
  - aw_ready_o = not full.
  - A push happens when aw_valid_i & aw_ready_o.
  - The FIFO has no fall-through: a pushed entry is visible at the head the cycle after the push.
- Per-port register rcvd[NoMstPorts] tracks B beats already collected for the head entry.
- Accumulators: resp_acc, user_acc (user OR-reduced).
- State COLLECT:
  - mst_b_ready_o[i] = head_valid & mask[i] & ~rcvd[i].
  - On each handshake, set rcvd[i] and fold resp/user into the accumulators.
  - Several ports may handshake in the same cycle; all are folded.
- Leaving COLLECT: when (rcvd | this cycle's handshakes) == mask, go to RESPOND.
- State RESPOND:
  - slv_b_valid_o = 1; all mst_b_ready_o = 0.
  - On slv_b_ready_i: pop the head, clear rcvd and the accumulators, go to COLLECT.
- Resp merge priority:
  - any DECERR(3) → 3;
  - else any SLVERR(2) → 2;
  - else all EXOKAY(1) → 1;
  - else OKAY(0).
- Empty mask (all zeros): the entry moves COLLECT→RESPOND in its first head cycle with resp = DECERR and user = 0.
- ID mismatch (mst_b_id_i[i] ≠ head id on a handshake) is a protocol violation:
  - a simulation assertion fires;
  - the beat is still accepted;
  - slv_b_id_o always carries the head ID.
- A B valid on a non-selected or already-collected port is held off (ready = 0), never dropped.

## Timing
- Reset (rst_i high, asynchronous): FIFO empty, state COLLECT, rcvd = 0, accumulators = 0.
  - aw_ready_o = 1; all mst_b_ready_o = 0; slv_b_valid_o = 0; slv_b_id_o/resp_o/user_o = 0.
- Reset asserted mid-transaction discards all pending entries and partial collections. No B is issued for them.
- Merged-response outputs are registered. Last master B handshake at cycle t → slv_b_valid_o = 1 at t+1.
- Minimum push-to-merged-B latency for a one-hot mask with B already valid: push at t, head at t+1, B handshake at t+1, slv_b_valid_o at t+2.
- slv_b_* is stable while slv_b_valid_o & ~slv_b_ready_i.
- Pop at cycle t → the next head is eligible to collect at t+1. Throughput is at most one merged B per 2 cycles.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- When full, a same-cycle pop does not raise aw_ready_o until the next cycle.
- Pointer wrap-around at MaxTrans is transparent. Occupancy counter width is $clog2(MaxTrans+1).

## Test plan
- Reset values: assert rst_i asynchronously mid-cycle.
  - Required: all outputs take their reset values immediately.
  - Required: aw_ready_o = 1 after release.
- Multicast OKAY join: push mask 4'b1011, id 5. Return B from ports 0, 3, 1 on three different cycles, each resp 0.
  - Required: exactly one slv_b with id 5, resp 0, one cycle after the port 1 handshake.
  - Required: port 2 ready stays 0 throughout.
- Error merge and simultaneous arrival: push mask 4'b1111. All four ports are valid in the same cycle with resp {0, 2, 1, 3}.
  - Required: all four are accepted that cycle; merged resp = 3.
  - Repeat with {1, 1, 1, 1} → merged resp 1.
- Ordering and backpressure: push 3 entries, ids 1, 2, 3, all mask 4'b0001. Port 0 presents B for all three back-to-back while slv_b_ready_i is held low for 5 cycles.
  - Required: merged B beats are issued in order 1, 2, 3.
  - Required: the second port 0 beat is not accepted before the first merged beat pops.
- FIFO full and wrap: push MaxTrans entries without responding.
  - Required: aw_ready_o = 0.
  - Then drain while pushing, for 3×MaxTrans total entries.
  - Required: no entry is lost or duplicated; ids are returned in order.
- Empty mask: push mask 0, id 7.
  - Required: slv_b_valid_o with id 7 and resp 3 two cycles after the push.
  - Required: no mst_b_ready_o is asserted.
